// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//   Target end of the MEM-stage load/store interface. Accepts one read or
//   write at a time, holds the pipeline via stall for LATENCY cycles, and
//   returns load data with a one-cycle rd_valid pulse.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   mem_to_reg : read request strobe
//   reg_to_mem : write request strobe
//   addr       : word address (only addr[ADDR_W-1:0] used)
//   wr_data    : store data, sampled at acceptance
//   rd_data    : load data, valid with rd_valid; holds between reads
//   rd_valid   : one-cycle pulse on read completion
//   stall      : combinational hold request to the MEM stage
//   err        : sticky, both strobes seen high at acceptance
// ---------------------------------------------------------------------------
module dmem_responder #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_to_reg,
   input  logic        reg_to_mem,
   input  logic [15:0] addr,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   output logic        stall,
   output logic        err
);

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned CNT_W    = 4;
   localparam int unsigned DEPTH    = 1 << ADDR_W;
   localparam int unsigned CNT_INIT = (LATENCY > 1) ? (LATENCY - 2) : 0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;
   logic                is_read_q, is_read_d;
   logic                err_d;
   logic                wr_en;
   logic                load;
   logic                req;
   logic [DATA_W-1:0]   mem [DEPTH];

   // Upper address bits alias onto the low ones by design.
   logic unused_addr_bits;
   assign unused_addr_bits = ^addr[15:ADDR_W];

   assign req = mem_to_reg | reg_to_mem;

   // State register and access context.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         is_read_q <= 1'b0;
         err       <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         is_read_q <= is_read_d;
         err       <= err_d;
         rd_valid  <= load;
         if (load) begin
            rd_data <= mem[idx_d];
         end
      end
   end

   // Storage is never cleared; writes commit on the acceptance edge.
   always_ff @(posedge clk) begin
      if (rst && wr_en) begin
         mem[idx_d] <= wr_data;
      end
   end

   // Next-state and access control.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      is_read_d = is_read_q;
      err_d     = err;
      wr_en     = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (req) begin
               // Write wins a strobe conflict; the read is dropped.
               is_read_d = mem_to_reg & ~reg_to_mem;
               idx_d     = addr[ADDR_W-1:0];
               wr_en     = reg_to_mem;
               if (mem_to_reg && reg_to_mem) begin
                  err_d = 1'b1;
               end
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = CNT_W'(CNT_INIT);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
            // The request still on the bus here is the completed one.
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      load = (state_d == S_RESP) && is_read_d;
   end

   assign stall = rst & (((state_q == S_IDLE) & req) | (state_q == S_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
// ---------------------------------------------------------------------------
// tb_dmem_responder
//   Three responders with LATENCY 2, 1 and 15. A driver issues directed
//   accesses and pushes expected load data into a queue; a monitor pops and
//   compares on every rd_valid pulse.
// ---------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int unsigned N = 3;

   typedef struct {
      int          k;
      logic [15:0] d;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        m2r      [N];
   logic        r2m      [N];
   logic [15:0] addr_s   [N];
   logic [15:0] wdata_s  [N];
   logic [15:0] rd_data  [N];
   logic        rd_valid [N];
   logic        stall    [N];
   logic        err      [N];

   exp_t exp_q[$];
   int   n_pass;
   int   n_total;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder #(
         .ADDR_W (10),
         .LATENCY((g == 0) ? 2 : ((g == 1) ? 1 : 15))
      ) dut (
         .clk       (clk),
         .rst       (rst),
         .mem_to_reg(m2r[g]),
         .reg_to_mem(r2m[g]),
         .addr      (addr_s[g]),
         .wr_data   (wdata_s[g]),
         .rd_data   (rd_data[g]),
         .rd_valid  (rd_valid[g]),
         .stall     (stall[g]),
         .err       (err[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
   endfunction

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s dut%0d: got %h expected %h at %0t", name, k, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   task automatic idle_all();
      for (int k = 0; k < N; k++) begin
         m2r[k] = 1'b0; r2m[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
      end
   endtask

   // One access on dut k; counts stall-high cycles up to the RESP cycle.
   task automatic access(input int k, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] exp_rd);
      int  n;
      bit  done;
      exp_t e;
      if (rd && !wr) begin
         e.k = k; e.d = exp_rd;
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      m2r[k] = rd; r2m[k] = wr; addr_s[k] = a; wdata_s[k] = wd;
      n = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (stall[k]) n++;
         else done = 1'b1;
      end
      check("stall_cycles", k, 32'(n), 32'(lat_of(k)));
      if (!done) check("stall_timeout", k, 32'(1), 32'(0));
      @(posedge clk); #1;
      m2r[k] = 1'b0; r2m[k] = 1'b0; addr_s[k] = '0; wdata_s[k] = '0;
   endtask

   // Scoreboard monitor: every rd_valid must match the oldest expectation.
   always @(negedge clk) begin
      for (int k = 0; k < N; k++) begin
         if (rd_valid[k] === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rd_valid", k, 32'(1), 32'(0));
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("resp_dut", k, 32'(k), 32'(e.k));
               check("rd_data", k, 32'(rd_data[k]), 32'(e.d));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_pass = 0; n_total = 0;
      rst = 1'b0;
      idle_all();

      // Reset held with random inputs: all outputs stay zero.
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         for (int k = 0; k < N; k++) begin
            m2r[k]     = 1'($urandom_range(0, 1));
            r2m[k]     = 1'($urandom_range(0, 1));
            addr_s[k]  = 16'($urandom);
            wdata_s[k] = 16'($urandom);
         end
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            check("rst_rd_data", k, 32'(rd_data[k]), 32'(0));
            check("rst_rd_valid", k, 32'(rd_valid[k]), 32'(0));
            check("rst_stall", k, 32'(stall[k]), 32'(0));
            check("rst_err", k, 32'(err[k]), 32'(0));
         end
      end
      @(posedge clk); #1;
      idle_all();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("idle_stall", 0, 32'(stall[0]), 32'(0));
      end

      // Write then read, LATENCY 2.
      access(0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, 16'h0);
      access(0, 1'b1, 1'b0, 16'h0005, 16'h0, 16'hBEEF);

      // Address wrap: 0x0403 aliases 0x0003.
      access(0, 1'b0, 1'b1, 16'h0403, 16'hA5A5, 16'h0);
      access(0, 1'b1, 1'b0, 16'h0003, 16'h0, 16'hA5A5);

      // rd_data holds across a write.
      access(0, 1'b0, 1'b1, 16'h0007, 16'h7777, 16'h0);
      check("rd_data_hold", 0, 32'(rd_data[0]), 32'hA5A5);
      check("err_clear", 0, 32'(err[0]), 32'(0));

      // Strobe conflict: write wins, err sticky.
      access(0, 1'b1, 1'b1, 16'h0010, 16'h0F0F, 16'h0);
      check("err_set", 0, 32'(err[0]), 32'(1));
      access(0, 1'b1, 1'b0, 16'h0010, 16'h0, 16'h0F0F);
      check("err_sticky", 0, 32'(err[0]), 32'(1));

      // Latency sweep.
      access(1, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0);
      access(1, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h1234);
      access(2, 1'b0, 1'b1, 16'h0020, 16'h1234, 16'h0);
      access(2, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h1234);
      access(2, 1'b0, 1'b1, 16'h0005, 16'h5555, 16'h0);

      // Reset during the WAIT of a read: aborted, no response.
      @(posedge clk); #1;
      m2r[2] = 1'b1; addr_s[2] = 16'h0005;
      repeat (4) @(negedge clk);
      check("mid_stall", 2, 32'(stall[2]), 32'(1));
      #2 rst = 1'b0;
      #1;
      check("mid_rst_stall", 2, 32'(stall[2]), 32'(0));
      check("mid_rst_rd_valid", 2, 32'(rd_valid[2]), 32'(0));
      check("mid_rst_rd_data", 2, 32'(rd_data[2]), 32'(0));
      check("mid_rst_err", 2, 32'(err[2]), 32'(0));
      check("mid_rst_err", 0, 32'(err[0]), 32'(0));
      idle_all();
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_stall", 2, 32'(stall[2]), 32'(0));
      access(2, 1'b1, 1'b0, 16'h0005, 16'h0, 16'h5555);

      repeat (5) @(negedge clk);
      check("queue_drained", 0, 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
